// File: rtl/nave_pkg.sv
// Shared types and constants for the player-ship controller: FSM states,
// key bit positions, default screen geometry and the per-axis step function.
package nave_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    INVULN  = 2'd2,
    FIM     = 2'd3
  } nave_state_t;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  // One axis step; sums are widened to 11 bits so pos+size+spd cannot wrap.
  function automatic logic [9:0] nave_step(
    input logic [9:0] pos,
    input logic       inc,
    input logic       dec,
    input logic [9:0] size,
    input logic [9:0] lim,
    input logic [9:0] spd,
    input logic       wrap
  );
    logic [10:0] p, s, l, d;
    p = {1'b0, pos};
    s = {1'b0, size};
    l = {1'b0, lim};
    d = {1'b0, spd};
    nave_step = pos;
    if (inc && !dec) begin
      if (p + s + d <= l) nave_step = pos + spd;
      else                nave_step = wrap ? 10'd0 : lim - size;
    end else if (dec && !inc) begin
      if (p >= d) nave_step = pos - spd;
      else        nave_step = wrap ? lim - size : 10'd0;
    end
  endfunction

endpackage

// File: rtl/nave_tick_gen.sv
// Movement tick strobe: counts 0..TICK_DIV-1 and fires one clock at the wrap.
// The count freezes while pausa is high; clr restarts it synchronously.
module nave_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pausa,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !pausa && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (!pausa) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/nave_ctrl_param.sv
// Two-axis player-ship controller: movement, lives, invulnerability blink and
// ball launch. Define NAVE_WRAP_EN for horizontal wrap-around instead of clamp.
module nave_ctrl_param
  import nave_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int NAVE_W       = 30,
  parameter int NAVE_H       = 30,
  parameter int X0           = 150,
  parameter int Y0           = 2,
  parameter int SPEED        = 2,
  parameter int TICK_DIV     = 833333,
  parameter int VIDAS0       = 3,
  parameter int INVULN_TICKS = 120,
  parameter int BLINK_TICKS  = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] keysout,
  input  logic       disparo,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       bateu,
  output logic       iniciarBola,
  output logic [9:0] largura_nave,
  output logic [9:0] altura_nave,
  output logic [9:0] x_nave,
  output logic [9:0] y_nave,
  output logic [3:0] vidas,
  output logic       piscando,
  output logic       fim_jogo
);

  localparam int TW = $clog2(INVULN_TICKS + 1) > 0 ? $clog2(INVULN_TICKS + 1) : 1;
  localparam int BW = $clog2(BLINK_TICKS + 1) > 0 ? $clog2(BLINK_TICKS + 1) : 1;

`ifdef NAVE_WRAP_EN
  localparam logic WRAP_X = 1'b1;
`else
  localparam logic WRAP_X = 1'b0;
`endif

  nave_state_t   state, state_next;
  logic          tick, launch, hit, inv_done;
  logic [9:0]    x, y;
  logic [3:0]    vidas_q;
  logic [TW-1:0] timer;
  logic [BW-1:0] blink;
  logic          pisc, ini;

  nave_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (CLOCK_50),
    .rst  (reset),
    .clr  (reiniciarJogo),
    .pausa(pausa),
    .tick (tick)
  );

  // tick is already masked by pausa, so only the direct events need the gate
  assign launch   = (state == ESPERA)  && disparo && !pausa;
  assign hit      = (state == JOGANDO) && bateu   && !pausa;
  assign inv_done = (state == INVULN)  && tick && (timer <= TW'(1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)              state <= ESPERA;
    else if (reiniciarJogo) state <= ESPERA;
    else                    state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ESPERA:  if (launch)   state_next = JOGANDO;
      JOGANDO: if (hit)      state_next = (vidas_q <= 4'd1) ? FIM : INVULN;
      INVULN:  if (inv_done) state_next = ESPERA;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x       <= 10'(X0);
      y       <= 10'(Y0);
      vidas_q <= 4'(VIDAS0);
      timer   <= '0;
      blink   <= '0;
      pisc    <= 1'b0;
      ini     <= 1'b0;
    end else if (reiniciarJogo) begin
      x       <= 10'(X0);
      y       <= 10'(Y0);
      vidas_q <= 4'(VIDAS0);
      timer   <= '0;
      blink   <= '0;
      pisc    <= 1'b0;
      ini     <= 1'b0;
    end else begin
      ini <= launch;
      if (tick && state != FIM) begin
        x <= nave_step(x, keysout[KEY_RIGHT], keysout[KEY_LEFT], 10'(NAVE_W),
                       10'(SCREEN_W), 10'(SPEED), WRAP_X);
        y <= nave_step(y, keysout[KEY_DOWN], keysout[KEY_UP], 10'(NAVE_H),
                       10'(SCREEN_H), 10'(SPEED), 1'b0);
      end
      if (hit) begin
        vidas_q <= (vidas_q != 4'd0) ? vidas_q - 4'd1 : 4'd0;
        timer   <= TW'(INVULN_TICKS);
        blink   <= '0;
        pisc    <= (vidas_q > 4'd1);
      end else if (state == INVULN && tick) begin
        if (timer <= TW'(1)) begin
          timer <= '0;
          blink <= '0;
          pisc  <= 1'b0;
        end else begin
          timer <= timer - 1'b1;
          if (blink == BW'(BLINK_TICKS - 1)) begin
            blink <= '0;
            pisc  <= ~pisc;
          end else begin
            blink <= blink + 1'b1;
          end
        end
      end
    end
  end

  assign iniciarBola  = ini;
  assign largura_nave = 10'(NAVE_W);
  assign altura_nave  = 10'(NAVE_H);
  assign x_nave       = x;
  assign y_nave       = y;
  assign vidas        = vidas_q;
  assign piscando     = pisc;
  assign fim_jogo     = (state == FIM);

endmodule

// File: tb/tb_nave_ctrl_param.sv
// Directed bench for nave_ctrl_param with a short tick (TICK_DIV=4).
// Expected values are hand-derived; honours NAVE_WRAP_EN for the right-edge case.
module tb_nave_ctrl_param;

  logic       CLOCK_50 = 1'b0;
  logic       reset, disparo, pausa, reiniciarJogo, bateu;
  logic [3:0] keysout;
  logic       iniciarBola, piscando, fim_jogo;
  logic [9:0] largura_nave, altura_nave, x_nave, y_nave;
  logic [3:0] vidas;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  int exp_x;

  nave_ctrl_param #(
    .TICK_DIV(4), .INVULN_TICKS(6), .BLINK_TICKS(2), .VIDAS0(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .keysout(keysout), .disparo(disparo),
    .pausa(pausa), .reiniciarJogo(reiniciarJogo), .bateu(bateu),
    .iniciarBola(iniciarBola), .largura_nave(largura_nave), .altura_nave(altura_nave),
    .x_nave(x_nave), .y_nave(y_nave), .vidas(vidas), .piscando(piscando),
    .fim_jogo(fim_jogo)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // hold keys for exactly n ticks (4n clocks covers n wraps at any phase)
  task automatic move(input logic [3:0] k, input int n);
    keysout = k;
    repeat (4 * n) @(negedge CLOCK_50);
    keysout = 4'b0000;
  endtask

  task automatic fire(output int n);
    n = 0;
    disparo = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (iniciarBola) n++;
    end
    disparo = 1'b0;
    repeat (2) begin
      @(negedge CLOCK_50);
      if (iniciarBola) n++;
    end
  endtask

  task automatic hit();
    bateu = 1'b1;
    @(negedge CLOCK_50);
    bateu = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; keysout = 4'b0; disparo = 1'b0; pausa = 1'b0;
    reiniciarJogo = 1'b0; bateu = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;

    chk("reset_x", int'(x_nave), 150);
    chk("reset_y", int'(y_nave), 2);
    chk("reset_vidas", int'(vidas), 3);
    chk("reset_ini", int'(iniciarBola), 0);
    chk("reset_pisc", int'(piscando), 0);
    chk("reset_fim", int'(fim_jogo), 0);
    chk("largura", int'(largura_nave), 30);
    chk("altura", int'(altura_nave), 30);

    move(4'b0001, 10);  chk("right10", int'(x_nave), 170);
    move(4'b0011, 5);   chk("opposed_x", int'(x_nave), 170);
    move(4'b1000, 1);   chk("up_to_0", int'(y_nave), 0);
    move(4'b1000, 1);   chk("up_clamp", int'(y_nave), 0);
    move(4'b0100, 3);   chk("down3", int'(y_nave), 6);
    move(4'b0001, 219); chk("right_608", int'(x_nave), 608);
    move(4'b0001, 1);   chk("right_610", int'(x_nave), 610);
`ifdef NAVE_WRAP_EN
    exp_x = 0;
`else
    exp_x = 610;
`endif
    move(4'b0001, 1);   chk("right_edge", int'(x_nave), exp_x);

    fire(pulses);       chk("launch_pulse", pulses, 1);

    hit();              chk("hit1_vidas", int'(vidas), 2);
                        chk("hit1_pisc", int'(piscando), 1);
    hit();              chk("invuln_ignore", int'(vidas), 2);
    repeat (8) @(negedge CLOCK_50); chk("blink_off", int'(piscando), 0);
    repeat (8) @(negedge CLOCK_50); chk("blink_on", int'(piscando), 1);
    repeat (7) @(negedge CLOCK_50); chk("invuln_end", int'(piscando), 0);

    hit();              chk("espera_ignore", int'(vidas), 2);
    fire(pulses);       chk("relaunch", pulses, 1);
    hit();              chk("hit2_vidas", int'(vidas), 1);
    repeat (24) @(negedge CLOCK_50);
    fire(pulses);       chk("relaunch2", pulses, 1);
    hit();              chk("hit3_vidas", int'(vidas), 0);
                        chk("fim", int'(fim_jogo), 1);
                        chk("fim_pisc", int'(piscando), 0);
    hit();              chk("vidas_sat", int'(vidas), 0);
    move(4'b0001, 3);   chk("fim_frozen", int'(x_nave), exp_x);
    fire(pulses);       chk("fim_nolaunch", pulses, 0);
                        chk("fim_hold", int'(fim_jogo), 1);

    reiniciarJogo = 1'b1; pausa = 1'b1; keysout = 4'b0001;
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b0;
    chk("restart_vidas", int'(vidas), 3);
    chk("restart_fim", int'(fim_jogo), 0);
    chk("restart_x", int'(x_nave), 150);
    chk("restart_y", int'(y_nave), 2);
    repeat (10) @(negedge CLOCK_50); chk("pause_x", int'(x_nave), 150);
    fire(pulses);       chk("pause_nolaunch", pulses, 0);
    pausa = 1'b0;
    repeat (3) @(negedge CLOCK_50); chk("tick_held_x", int'(x_nave), 150);
    @(negedge CLOCK_50);            chk("tick_after_pause", int'(x_nave), 152);
    keysout = 4'b0000;

    fire(pulses);       chk("launch3", pulses, 1);
    pausa = 1'b1;
    hit();              chk("pause_drop_hit", int'(vidas), 3);
    pausa = 1'b0;
    hit();              chk("hit_after_pause", int'(vidas), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
